// File: rtl/latex_uart_tx_if.sv
// Byte handshake between the character sequencer and the UART serializer.
interface latex_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/latex_uart_tx.sv
// FIFO-buffered UART transmitter for rendered LaTeX text, 8N1 by default.
// Define LATEX_UART_TX_PARITY_EN to send an even-parity bit (8E1 framing).
module latex_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  latex_uart_tx_if.slave                s_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef LATEX_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_level;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  state_t      r_state;
  state_t      w_state_next;
  logic [CW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        w_bit_end;
  logic        w_tx_next;
  logic        w_busy_next;
  logic        r_tx;
  logic        r_busy;
`ifdef LATEX_UART_TX_PARITY_EN
  logic        r_parity;
`endif

  // Flags decode from the registered level, so a same-cycle pop never frees a slot early.
  assign w_full        = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty       = (r_level == '0);
  assign w_push        = s_in.in_valid && !w_full;
  assign s_in.in_ready = !w_full;
  assign w_bit_end     = (r_baud == CW'(CLKS_PER_BIT - 1));

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_level;

  // NOTE: storage array carries no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_in.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // State register with baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
`ifdef LATEX_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE || w_bit_end) r_baud <= '0;
      else                                r_baud <= r_baud + 1'b1;
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr[AW-1:0]];
        r_bit    <= '0;
`ifdef LATEX_UART_TX_PARITY_EN
        r_parity <= ^r_mem[r_rd_ptr[AW-1:0]];
`endif
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && r_bit == 3'd7) begin
`ifdef LATEX_UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef LATEX_UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP: begin
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (r_state != S_IDLE) || !w_empty;
    case (r_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_shift[0];
`ifdef LATEX_UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // tx and busy share one register stage, so busy drops exactly as the stop bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: doc/latex_uart_tx.md
# latex_uart_tx

Byte-stream serializer downstream of the transformer. Accepts the ASCII characters of a rendered LaTeX transform (the `lhs`/`rhs` bytes, selected and sequenced by the top level) through a valid/ready handshake. It buffers them in a small FIFO and shifts them out on a single UART TX pin, so the transform text can be read on a terminal instead of the parallel output bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Legal range is ≥ 2.
- `FIFO_DEPTH`, default 8: character FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  : single clock.
- `rst`  in  1  : reset, synchronous and active-high.
- `in_data`  in  8  : ASCII character from the transformer path.
- `in_valid`  in  1  : `in_data` is valid.
- `in_ready`  out  1  : FIFO can accept a byte. A byte is accepted on a `clk` edge where `in_valid && in_ready`.
- `tx`  out  1  : UART serial output, idle high, LSB first.
- `busy`  out  1  : high while a frame is on the line or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  : bytes currently queued, range 0..FIFO_DEPTH.

## Operation
- FIFO:
  - Write/read pointers are $clog2(FIFO_DEPTH)+1 bits. They wrap naturally.
  - full = level==FIFO_DEPTH. empty = level==0.
  - `in_ready` = !full, decoded from registered level.
  - Push when full is impossible. A pop in the same cycle does not free the slot for that cycle.
  - Pop only when !empty. Push into an empty FIFO is not visible to the TX FSM until the next cycle.
  - Simultaneous push and pop leave the level unchanged.
- TX FSM states are IDLE, START, DATA, PARITY (present only with the macro), and STOP.
  - The baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. It advances state when it reaches CLKS_PER_BIT-1.
  - IDLE: if !empty, pop the head into the shift register and go to START. Otherwise stay.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0]. Shift right each bit time. After bit index 7, go to PARITY if enabled, else STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - if !empty, pop and go directly to START, giving no idle gap between frames;
    - otherwise go to IDLE.
- `tx` is registered and driven from the state and shift register. It has no combinational path from the inputs.
- `busy` = (state!=IDLE) || !empty.

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `fifo_level`=0. FSM is in IDLE, counters are 0, FIFO pointers are 0.
- Reset asserted mid-frame: the frame is aborted and the FIFO contents are discarded. `tx`=1 from the first edge with `rst` high. Nothing is resumed after reset.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE.
  - Pop occurs at edge N+1.
  - `tx` falls after edge N+2.
  - `fifo_level` reads 1 after edge N and 0 after edge N+1.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames: the falling start edges are exactly one frame length apart.
- Throughput: one byte per frame length. `in_ready` drops when the level reaches FIFO_DEPTH and rises on the cycle after the next pop.

## Configuration
- `LATEX_UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in;
  - one even-parity bit (XOR of the 8 data bits) is sent after data bit 7, for CLKS_PER_BIT cycles;
  - the frame is 8E1, 11 bit times.
- Undefined: no PARITY state or logic, and the frame is 8N1, 10 bit times.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0x5C ('\\').
  - `tx` is low 2 cycles after accept.
  - Then 4-cycle bits 0,0,1,1,1,0,1,0, then high 4 cycles.
  - `busy` falls after 40 cycles from tx fall.
- Back-to-back: push 0x66, 0x72, 0x61, 0x63 ("frac") in consecutive cycles.
  - Start edges are 40 cycles apart (44 with parity).
  - Decoded bytes match in order. `tx` never idles between frames.
- Full FIFO, FIFO_DEPTH=8: hold `in_valid` with 12 distinct bytes.
  - `in_ready` deasserts when `fifo_level`=8.
  - Exactly 12 bytes are eventually transmitted, in order, with none lost or duplicated.
- Reset mid-frame: assert `rst` for 1 cycle during DATA of 0x7B with 3 bytes queued.
  - `tx`=1 next cycle, `fifo_level`=0, `busy`=0.
  - No further frames follow.
  - A subsequent push of 0x7D is transmitted normally.
- Parity (macro defined): send 0x73 (five ones) then 0x7B (six ones). The parity bits are 1 and 0 respectively, and the frames are 11 bit times.
- Idle stability: no pushes for 1000 cycles after reset. `tx` stays 1, `busy` stays 0, and `in_ready` stays 1.
